ex_control_multirow: RTL
========================

# ex_control_multirow

Parametrised exposure/readout controller for the camera sensor array. It sits between the front-panel synchroniser and the pixel array/ADC.
- On Init it erases, exposes for a programmable time, then reads out ROWS rows in sequence, each with an active-low read enable and one ADC strobe.
- The exposure time is adjustable in Idle and saturates at configurable limits.
- Exposure timing uses an internal prescaled timer, so no external timer/overflow handshake is needed.

## Interface
- ROWS, 2: number of sensor rows read out; ≥1.
- EXP_W, 5: width of exposure-time register; must hold EXP_MAX.
- EXP_MIN, 2: minimum exposure time, in units.
- EXP_MAX, 30: maximum exposure time, in units.
- EXP_INIT, 5: exposure time after reset; EXP_MIN ≤ EXP_INIT ≤ EXP_MAX.
- UNIT_CYCLES, 1000: Clk cycles per exposure unit; ≥1.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Init  in  1  start request; level-sampled in Idle only.
- Exp_increase  in  1  +1 unit request; level-sampled in Idle only.
- Exp_decrease  in  1  −1 unit request; level-sampled in Idle only.
- Erase  out  1  pixel erase; high in Idle.
- Expose  out  1  exposure enable.
- NRE  out  ROWS  active-low row read enables; bit r = row r.
- ADC  out  1  one-cycle conversion strobe.
- Busy  out  1  high outside Idle.
- Exp_time  out  EXP_W  current programmed exposure time.

## Operation
- All outputs are registered. Reset values: Erase=1, Expose=0, NRE=all ones, ADC=0, Busy=0, Exp_time=EXP_INIT; state Idle.
- States: Idle, Exposure, Readout.
- Idle:
  - Erase=1.
  - Init=1 → Exposure; the exposure time is latched from Exp_time into the timer.
  - Otherwise the exposure register is adjusted: Exp_increase alone → +1, saturating at EXP_MAX; Exp_decrease alone → −1, saturating at EXP_MIN; both high or neither → unchanged.
  - When Init and an adjust request arrive in the same cycle, Init wins and Exp_time is unchanged.
- Exposure:
  - Erase=0, Expose=1, Busy=1.
  - Lasts exactly latched_time × UNIT_CYCLES cycles, then → Readout with row=0.
  - Init and the adjust inputs are ignored.
- Readout:
  - Erase=0, Expose=0, Busy=1.
  - Each row occupies a 4-cycle slot, with phase counted from 0: NRE[row]=0 in phases 0–2; ADC=1 in phase 1 only; phase 3 is a gap with all NRE high.
  - After phase 3 of row ROWS−1 → Idle. Otherwise row increments.
  - At most one NRE bit is low at any time.
- Returning to Idle re-asserts Erase. If Init is still high, a new Exposure starts after exactly one Idle cycle; there is no edge detection.
- Reset in any state aborts immediately to reset values. The latched exposure time and row counter are cleared; Exp_time returns to EXP_INIT.
- Arithmetic: unsigned; the saturation compare is done before the add/subtract, so Exp_time never wraps. Unit counter width is $clog2(UNIT_CYCLES); row counter width is $clog2(ROWS), minimum 1.

## Timing
- Init high at edge k in Idle → after edge k: Expose=1, Erase=0, Busy=1.
- Expose stays high for T×UNIT_CYCLES cycles. Readout phase 0 is visible in the first cycle after that.
- Readout lasts 4×ROWS cycles. The whole capture, Init edge to Busy=0, lasts T×UNIT_CYCLES + 4×ROWS cycles.
- Adjust request at edge k in Idle → new Exp_time visible after edge k. Holding the request high steps Exp_time once per cycle.

## Structure
- Shared package ex_ctrl_pkg: state enum (IDLE, EXPOSURE, READOUT), SLOT_LEN=4, ADC_PHASE=1, NRE_LAST_PHASE=2.
- One sub-module, exp_unit_timer: a prescaler of UNIT_CYCLES chained to an EXP_W down-counter. It takes load/value and produces a done pulse; the parent FSM owns all outputs.

## Test plan
- Reset mid-Exposure → next cycle Erase=1, Expose=0, NRE=all ones, Exp_time=EXP_INIT, Busy=0.
- UNIT_CYCLES=3, ROWS=2, Exp_time=5, Init pulse → Expose high exactly 15 cycles. NRE=2'b10 for 3 cycles with ADC on the 2nd, one gap, then NRE=2'b01 the same way. Busy drops after 15+8 cycles.
- Exp_increase held 40 cycles in Idle from 5 → Exp_time stops at 30. Exp_decrease held 40 cycles → stops at 2. Both inputs high → unchanged.
- Exp_increase during Exposure → Exp_time unchanged. Init together with Exp_increase in Idle → capture starts and Exp_time unchanged.
- Init held high continuously → captures repeat, each separated by exactly one Idle cycle with Erase=1.
- ROWS=4 → NRE walks 1110, 1101, 1011, 0111; exactly 4 ADC pulses; never more than one NRE bit low.

Source files
------------

// File: rtl/ex_ctrl_pkg.sv
// Shared types and readout slot constants for the exposure/readout controller.
package ex_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPOSURE,
        READOUT
    } state_t;

    localparam int unsigned SLOT_LEN       = 4;
    localparam int unsigned ADC_PHASE      = 1;
    localparam int unsigned NRE_LAST_PHASE = 2;

endpackage

// File: rtl/exp_unit_timer.sv
// Exposure timer: a UNIT_CYCLES prescaler chained to an EXP_W unit down-counter.
module exp_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 1000,
    parameter int unsigned EXP_W       = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [EXP_W-1:0] value,
    output logic             done
);

    localparam int unsigned PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    logic [PRE_W-1:0] pre;
    logic [EXP_W-1:0] units;
    logic             pre_wrap;

    assign pre_wrap = (pre == PRE_W'(UNIT_CYCLES - 1));
    // Fires on the last cycle of the final unit so the parent leaves Exposure exactly on time.
    assign done     = pre_wrap && (units == EXP_W'(1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pre   <= '0;
            units <= '0;
        end else if (load) begin
            pre   <= '0;
            units <= value;
        end else if (units != '0) begin
            if (pre_wrap) begin
                pre   <= '0;
                units <= units - 1'b1;
            end else begin
                pre   <= pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_control_multirow.sv
// Exposure/readout controller: erase in Idle, timed exposure, then ROWS readout slots.
module ex_control_multirow
    import ex_ctrl_pkg::*;
#(
    parameter int unsigned ROWS        = 2,
    parameter int unsigned EXP_W       = 5,
    parameter int unsigned EXP_MIN     = 2,
    parameter int unsigned EXP_MAX     = 30,
    parameter int unsigned EXP_INIT    = 5,
    parameter int unsigned UNIT_CYCLES = 1000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    output logic             Erase,
    output logic             Expose,
    output logic [ROWS-1:0]  NRE,
    output logic             ADC,
    output logic             Busy,
    output logic [EXP_W-1:0] Exp_time
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned PH_W  = $clog2(SLOT_LEN);

    state_t           state, state_n;
    logic [PH_W-1:0]  phase, phase_n;
    logic [ROW_W-1:0] row, row_n;
    logic [EXP_W-1:0] exp_n;
    logic             load, done;
    logic             erase_n, expose_n, adc_n, busy_n;
    logic [ROWS-1:0]  nre_n;

    exp_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES),
        .EXP_W      (EXP_W)
    ) u_timer (
        .Clk  (Clk),
        .Reset(Reset),
        .load (load),
        .value(Exp_time),
        .done (done)
    );

    always_comb begin
        state_n = state;
        phase_n = phase;
        row_n   = row;
        exp_n   = Exp_time;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (Init) begin
                    state_n = EXPOSURE;
                    load    = 1'b1;
                end else if (Exp_increase && !Exp_decrease) begin
                    if (Exp_time < EXP_W'(EXP_MAX)) exp_n = Exp_time + 1'b1;
                end else if (Exp_decrease && !Exp_increase) begin
                    if (Exp_time > EXP_W'(EXP_MIN)) exp_n = Exp_time - 1'b1;
                end
            end
            EXPOSURE: begin
                if (done) begin
                    state_n = READOUT;
                    phase_n = '0;
                    row_n   = '0;
                end
            end
            READOUT: begin
                if (phase == PH_W'(SLOT_LEN - 1)) begin
                    phase_n = '0;
                    if (row == ROW_W'(ROWS - 1)) state_n = IDLE;
                    else                          row_n   = row + 1'b1;
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        erase_n  = (state_n == IDLE);
        expose_n = (state_n == EXPOSURE);
        busy_n   = (state_n != IDLE);
        adc_n    = (state_n == READOUT) && (phase_n == PH_W'(ADC_PHASE));
        nre_n    = '1;
        if (state_n == READOUT && phase_n <= PH_W'(NRE_LAST_PHASE)) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (row_n == ROW_W'(r)) nre_n[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            phase    <= '0;
            row      <= '0;
            Exp_time <= EXP_W'(EXP_INIT);
            Erase    <= 1'b1;
            Expose   <= 1'b0;
            NRE      <= '1;
            ADC      <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            row      <= row_n;
            Exp_time <= exp_n;
            Erase    <= erase_n;
            Expose   <= expose_n;
            NRE      <= nre_n;
            ADC      <= adc_n;
            Busy     <= busy_n;
        end
    end

endmodule
